uart_tx_arbiter: RTL



---
 rtl/uart_tx_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between NREQ byte-producing requesters.
// Requesters are served round-robin, one byte per grant. The arbiter loads
// the winning byte into the transmitter and then follows tx_empty: first it
// waits for the transmitter to go busy, then for it to become free again.
// If the transmitter never goes busy after a load, a watchdog abandons the
// byte after TIMEOUT cycles and pulses timeout_err.
//
// Build option:
//   UART_ARB_LOCK_EN  When defined, the requester served last is granted
//                     again ahead of rotation while it keeps req high. A
//                     multi-byte message is then sent back to back. When
//                     undefined, the arbiter is pure round-robin per byte.
//
// Parameters:
//   NREQ     number of requesters (2..8)
//   IDW      width of the grant index, at least clog2(NREQ)
//   TIMEOUT  cycles allowed for tx_empty to fall after a load
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   req          per-requester byte-pending level, held until ack
//   req_data     flattened request bytes, requester i at [8i+7:8i]
//   ack          one-cycle pulse, byte of requester i accepted
//   tx_data      byte presented to the transmitter
//   ld_tx_data   one-cycle load strobe to the transmitter
//   tx_enable    transmitter enable, high from the first edge after reset
//   tx_empty     transmitter holding register empty (high = free)
//   busy         arbiter owns the transmitter
//   grant_id     index of the current or last granted requester
//   timeout_err  one-cycle pulse when the watchdog expires
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*8-1:0]   req_data,
    output logic [NREQ-1:0]     ack,
    output logic [7:0]          tx_data,
    output logic                ld_tx_data,
    output logic                tx_enable,
    input  logic                tx_empty,
    output logic                busy,
    output logic [IDW-1:0]      grant_id,
    output logic                timeout_err
);

    localparam int             WDW       = $clog2(TIMEOUT) + 1;
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);
    localparam logic [IDW-1:0] LAST_INIT = IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_EMPTY
    } state_t;

    state_t         state;
    logic [IDW-1:0] last;
    logic [WDW-1:0] wdog;

    logic [IDW-1:0] winner;
    logic [IDW-1:0] cand;
    logic           found;
    logic [7:0]     win_byte;

    // Pick the next requester to serve. The scan starts one past the last
    // granted index and wraps modulo NREQ, so the requester that was just
    // served always ends up with the lowest priority. Taking the first hit
    // of an ascending scan keeps the rotation strict. With the lock option,
    // a requester that still holds req after its grant keeps the
    // transmitter and the rotation is bypassed.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last) + k) % NREQ);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
`ifdef UART_ARB_LOCK_EN
        if (req[last]) begin
            winner = last;
            found  = 1'b1;
        end
`endif
    end

    // Select the winner's byte from the flattened data bus. A loop over
    // constant slices avoids a variable part-select on the wide bus.
    always_comb begin
        win_byte = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == IDW'(i)) begin
                win_byte = req_data[8*i +: 8];
            end
        end
    end

    // Main sequencer. All outputs are registered here.
    //
    // The strobes (ack, ld_tx_data, timeout_err) default to zero every
    // cycle, so each one is a single-cycle pulse.
    //
    // IDLE grants only when the transmitter reports empty. The grant loads
    // the byte, acks the requester, moves the rotation pointer and clears
    // the watchdog.
    //
    // WAIT_BUSY waits for the transmitter to take the byte (tx_empty low).
    // If that never happens within TIMEOUT cycles of the load, the byte is
    // dropped. It was already acked, so it is not retried.
    //
    // WAIT_EMPTY waits for the frame to finish. Returning through IDLE
    // before the next grant guarantees at least one idle cycle between
    // loads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            last        <= LAST_INIT;
            wdog        <= '0;
            ack         <= '0;
            tx_data     <= '0;
            ld_tx_data  <= 1'b0;
            tx_enable   <= 1'b0;
            busy        <= 1'b0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
        end else begin
            tx_enable   <= 1'b1;
            ack         <= '0;
            ld_tx_data  <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (found && tx_empty) begin
                        tx_data     <= win_byte;
                        ld_tx_data  <= 1'b1;
                        ack[winner] <= 1'b1;
                        grant_id    <= winner;
                        last        <= winner;
                        wdog        <= '0;
                        busy        <= 1'b1;
                        state       <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (!tx_empty) begin
                        state <= WAIT_EMPTY;
                    end else if (wdog == WDOG_LAST) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        wdog <= wdog + WDW'(1);
                    end
                end
                WAIT_EMPTY: begin
                    if (tx_empty) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
